ce_multigen: RTL and testbench

Parametrised multi-channel clock-enable generator for the BK0010/BK0011M core, running on `clk_sys`. It drives the CPU, PSG and video domains and replaces the hand-written divider logic. Each channel produces a positive-phase enable `ce_p` and a negative-phase enable `ce_n` from a per-channel, per-speed divisor. Speed changes (turbo modes) are applied only at a master-channel period boundary while the bus is idle, and re-phase all speed-following channels together.

---
 rtl/ce_multigen.sv | 106 ++++++++++
 tb/tb_ce_multigen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ce_multigen.sv
// Multi-channel clock-enable generator: per-channel divisors with positive/negative-phase
// enables and turbo speed changes applied at an idle master-period boundary.
module ce_multigen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SPEEDS   = 2,
    parameter int unsigned DIV_W    = 6,
    parameter int unsigned SW       = (SPEEDS > 1) ? $clog2(SPEEDS) : 1
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic [CHANNELS*SPEEDS*DIV_W-1:0] div_cfg,
    input  logic [CHANNELS-1:0]              switch_mask,
    input  logic [SW-1:0]                    speed_req,
    input  logic                             safe,
    output logic [CHANNELS-1:0]              ce_p,
    output logic [CHANNELS-1:0]              ce_n,
    output logic [SW-1:0]                    speed_cur,
    output logic                             switch_done
);

    localparam int unsigned CFG_W = CHANNELS * SPEEDS * DIV_W;
    localparam int unsigned HW    = DIV_W + 1;

    logic [CHANNELS-1:0][DIV_W-1:0] cnt_q;
    logic [CHANNELS-1:0][DIV_W-1:0] dl_q;
    logic [CHANNELS-1:0][DIV_W-1:0] cnt_d;
    logic [CHANNELS-1:0][DIV_W-1:0] dl_d;
    logic [CHANNELS-1:0][DIV_W-1:0] dl_rst_c;
    logic [CHANNELS-1:0][HW-1:0]    half_c;
    logic [CHANNELS-1:0][SW-1:0]    es_c;
    logic [CHANNELS-1:0]            follow_c;
    logic [CHANNELS-1:0]            wrap_c;
    logic [CHANNELS-1:0]            ce_p_d;
    logic [CHANNELS-1:0]            ce_n_d;
    logic                           req_ok_c;
    logic                           switch_c;

    // Divisor for channel ch at speed spd from the flattened configuration bus.
    function automatic logic [DIV_W-1:0] cfg_sel(input logic [CFG_W-1:0] cfg,
                                                  input int unsigned    ch,
                                                  input logic [SW-1:0]  spd);
        return cfg[(ch * SPEEDS + 32'(spd)) * DIV_W +: DIV_W];
    endfunction

    // Per-channel wrap/phase decode, switch decision and next counter state.
    always_comb begin
        cnt_d    = '0;
        dl_d     = '0;
        dl_rst_c = '0;
        half_c   = '0;
        es_c     = '0;
        follow_c = '0;
        wrap_c   = '0;
        ce_p_d   = '0;
        ce_n_d   = '0;
        req_ok_c = (32'(speed_req) < SPEEDS) && (speed_req != speed_cur);

        for (int unsigned c = 0; c < CHANNELS; c++) begin
            follow_c[c] = switch_mask[c] || (c == 0);
            es_c[c]     = follow_c[c] ? speed_cur : SW'(0);
            wrap_c[c]   = (cnt_q[c] == dl_q[c]);
            // Half period at DIV_W+1 bits so the all-ones divisor cannot overflow.
            half_c[c]   = (HW'(dl_q[c]) + HW'(1)) >> 1;
            ce_p_d[c]   = (cnt_q[c] == '0);
            ce_n_d[c]   = (HW'(cnt_q[c]) == half_c[c]);
            dl_rst_c[c] = cfg_sel(div_cfg, c, SW'(0));
        end

        switch_c = wrap_c[0] && safe && req_ok_c;

        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (switch_c && follow_c[c]) begin
                cnt_d[c] = '0;
                dl_d[c]  = cfg_sel(div_cfg, c, speed_req);
            end else if (wrap_c[c]) begin
                cnt_d[c] = '0;
                dl_d[c]  = cfg_sel(div_cfg, c, es_c[c]);
            end else begin
                cnt_d[c] = cnt_q[c] + DIV_W'(1);
                dl_d[c]  = dl_q[c];
            end
        end
    end

    // State and registered outputs; reset wins over a coincident switch.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q       <= '0;
            dl_q        <= dl_rst_c;
            speed_cur   <= '0;
            switch_done <= 1'b0;
            ce_p        <= '0;
            ce_n        <= '0;
        end else begin
            cnt_q       <= cnt_d;
            dl_q        <= dl_d;
            ce_p        <= ce_p_d;
            ce_n        <= ce_n_d;
            switch_done <= switch_c;
            if (switch_c) begin
                speed_cur <= speed_req;
            end
        end
    end

endmodule

// File: tb/tb_ce_multigen.sv
// Directed bench for ce_multigen: table of hand-computed key-cycle vectors plus full
// per-cycle traces for steady state, switching, blocking, masking, edits and reset.
module tb_ce_multigen;

    localparam int NCYC = 64;
    localparam int NV   = 23;
    localparam int NEVER = 1000;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [19:0] div_cfg;
    logic [1:0]  switch_mask;
    logic [0:0]  speed_req;
    logic        safe;
    logic [1:0]  ce_p;
    logic [1:0]  ce_n;
    logic [0:0]  speed_cur;
    logic        switch_done;

    logic [14:0] div_cfg3;
    logic [1:0]  speed_req3;
    logic [0:0]  ce_p3;
    logic [0:0]  ce_n3;
    logic [1:0]  speed_cur3;
    logic        switch_done3;

    always #5 clk_sys = ~clk_sys;

    ce_multigen #(.CHANNELS(2), .SPEEDS(2), .DIV_W(5)) u_dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .div_cfg     (div_cfg),
        .switch_mask (switch_mask),
        .speed_req   (speed_req),
        .safe        (safe),
        .ce_p        (ce_p),
        .ce_n        (ce_n),
        .speed_cur   (speed_cur),
        .switch_done (switch_done)
    );

    // Three speeds, one channel: used with an out-of-range speed request.
    ce_multigen #(.CHANNELS(1), .SPEEDS(3), .DIV_W(5)) u_dut3 (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .div_cfg     (div_cfg3),
        .switch_mask (1'b1),
        .speed_req   (speed_req3),
        .safe        (safe),
        .ce_p        (ce_p3),
        .ce_n        (ce_n3),
        .speed_cur   (speed_cur3),
        .switch_done (switch_done3)
    );

    typedef struct {
        int         scn;
        int         cyc;
        logic [1:0] p;
        logic [1:0] n;
        logic       spd;
        logic       done;
    } vec_t;

    vec_t       vecs [NV];
    logic [5:0] cap_main [NCYC];
    logic [4:0] cap_u3 [NCYC];
    int         n_vec = 0;
    int         n_err = 0;

    int sc_mask, sc_c1s0, req_on, req_off, safe_lo, safe_hi, edit_at, rst_lo, rst_hi;

    function automatic bit per(input int c, input int first, input int period);
        return (c >= first) && (((c - first) % period) == 0);
    endfunction

    // Expected {ce_p[1:0], ce_n[1:0], speed_cur, switch_done} per scenario and cycle.
    function automatic logic [5:0] exp_main(input int s, input int c);
        logic p0, p1, n0, n1, spd, done;
        int   s2, c2;
        p0 = 1'b0; p1 = 1'b0; n0 = 1'b0; n1 = 1'b0; spd = 1'b0; done = 1'b0;
        s2 = s;
        c2 = c;
        if (s == 7) begin
            if (c <= 30) s2 = 2;
            else if (c >= 33) begin s2 = 1; c2 = c - 32; end
            else s2 = 0;
        end
        case (s2)
            1: begin
                p0 = per(c2, 1, 24); n0 = per(c2, 13, 24);
                p1 = per(c2, 1, 8);  n1 = per(c2, 5, 8);
            end
            2, 4: begin
                p0 = (c2 == 1) || per(c2, 25, 12);
                n0 = (c2 == 13) || per(c2, 31, 12);
                spd = (c2 >= 24); done = (c2 == 24);
                if (s2 == 2) begin
                    p1 = (c2 < 25 && per(c2, 1, 8)) || per(c2, 25, 4);
                    n1 = (c2 < 25 && per(c2, 5, 8)) || per(c2, 27, 4);
                end else begin
                    p1 = per(c2, 1, 7); n1 = per(c2, 4, 7);
                end
            end
            3: begin
                p0 = (c2 <= 49 && per(c2, 1, 24)) || per(c2, 49, 12);
                n0 = (c2 < 48 && per(c2, 13, 24)) || per(c2, 55, 12);
                p1 = (c2 < 49 && per(c2, 1, 8)) || per(c2, 49, 4);
                n1 = (c2 < 48 && per(c2, 5, 8)) || per(c2, 51, 4);
                spd = (c2 >= 48); done = (c2 == 48);
            end
            5: begin
                p0 = per(c2, 1, 24); n0 = per(c2, 13, 24);
                p1 = (c2 == 1) || (c2 == 9) || (c2 >= 17);
                n1 = (c2 == 5) || (c2 == 13) || (c2 >= 17);
            end
            default: ;
        endcase
        return {p1, p0, n1, n0, spd, done};
    endfunction

    function automatic logic [4:0] exp_u3(input int c);
        return {logic'(per(c, 1, 6)), logic'(per(c, 4, 6)), 2'b00, 1'b0};
    endfunction

    task automatic check(input string name, input int cyc, input logic [5:0] act,
                         input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got {ce_p,ce_n,spd,done}=%b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    // Cycle k is the interval after edge k; edge 0 is the last edge sampling reset high.
    task automatic run_scn();
        reset       = 1'b1;
        speed_req   = 1'b0;
        safe        = 1'b1;
        switch_mask = 2'(sc_mask);
        div_cfg     = {5'd3, 5'(sc_c1s0), 5'd11, 5'd23};
        div_cfg3    = {5'd1, 5'd2, 5'd5};
        speed_req3  = 2'd3;
        repeat (3) @(posedge clk_sys);
        for (int k = 0; k < NCYC; k++) begin
            #1;
            reset     = (k >= rst_lo) && (k <= rst_hi);
            speed_req = 1'((k >= req_on) && (k < req_off));
            safe      = !((k >= safe_lo) && (k <= safe_hi));
            if (k >= edit_at) div_cfg[14:10] = 5'd0;
            @(negedge clk_sys);
            cap_main[k] = {ce_p, ce_n, speed_cur, switch_done};
            cap_u3[k]   = {ce_p3, ce_n3, speed_cur3, switch_done3};
            @(posedge clk_sys);
        end
    endtask

    initial begin
        vecs[0]  = '{1, 0,  2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1, 1,  2'b11, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1, 5,  2'b00, 2'b10, 1'b0, 1'b0};
        vecs[3]  = '{1, 13, 2'b00, 2'b11, 1'b0, 1'b0};
        vecs[4]  = '{1, 25, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{2, 23, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[6]  = '{2, 24, 2'b00, 2'b00, 1'b1, 1'b1};
        vecs[7]  = '{2, 25, 2'b11, 2'b00, 1'b1, 1'b0};
        vecs[8]  = '{2, 27, 2'b00, 2'b10, 1'b1, 1'b0};
        vecs[9]  = '{2, 31, 2'b00, 2'b11, 1'b1, 1'b0};
        vecs[10] = '{2, 37, 2'b11, 2'b00, 1'b1, 1'b0};
        vecs[11] = '{3, 24, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{3, 25, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[13] = '{3, 48, 2'b00, 2'b00, 1'b1, 1'b1};
        vecs[14] = '{3, 49, 2'b11, 2'b00, 1'b1, 1'b0};
        vecs[15] = '{5, 16, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[16] = '{5, 17, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[17] = '{5, 18, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[18] = '{7, 31, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[19] = '{7, 33, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[20] = '{8, 24, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[21] = '{8, 25, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[22] = '{8, 48, 2'b00, 2'b00, 1'b1, 1'b1};

        for (int s = 1; s <= 8; s++) begin
            sc_mask = 3; sc_c1s0 = 7;
            req_on = NEVER; req_off = NEVER;
            safe_lo = NEVER; safe_hi = NEVER;
            edit_at = NEVER; rst_lo = NEVER; rst_hi = NEVER;
            case (s)
                2: req_on = 5;
                3: begin req_on = 5; safe_lo = 20; safe_hi = 30; end
                4: begin req_on = 5; sc_mask = 1; sc_c1s0 = 6; end
                5: edit_at = 12;
                7: begin req_on = 5; req_off = 30; rst_lo = 30; rst_hi = 31; end
                8: begin req_on = 5; rst_lo = 23; rst_hi = 23; end
                default: ;
            endcase
            run_scn();
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].scn == s) begin
                    check($sformatf("vec%0d_s%0d", i, s), vecs[i].cyc, cap_main[vecs[i].cyc],
                          {vecs[i].p, vecs[i].n, vecs[i].spd, vecs[i].done});
                end
            end
            if (s <= 5 || s == 7) begin
                for (int k = 0; k < NCYC; k++) begin
                    check($sformatf("trace_s%0d", s), k, cap_main[k], exp_main(s, k));
                end
            end
            if (s == 6) begin
                for (int k = 0; k < NCYC; k++) begin
                    check("oor_speed3", k, {1'b0, cap_u3[k]}, {1'b0, exp_u3(k)});
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
